// File: rtl/noc_packetizer_if.sv
// -----------------------------------------------------------------------------
// noc_packetizer_if
// Bundles the two links of the NoC packetizer:
//   - write-FIFO read side : fifo_rd_en (pop), fifo_rd_data (entry, valid the
//                            cycle after a pop), fifo_empty
//   - flit link            : flit_valid / flit_data / flit_ready
// Modports:
//   master : the packetizer's view (drives pop request and flit link)
//   slave  : the environment's view (FIFO + router side)
// -----------------------------------------------------------------------------
interface noc_packetizer_if;
    logic        fifo_rd_en;
    logic [63:0] fifo_rd_data;
    logic        fifo_empty;
    logic        flit_valid;
    logic [33:0] flit_data;
    logic        flit_ready;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        output flit_valid,
        output flit_data,
        input  flit_ready
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        input  flit_valid,
        input  flit_data,
        output flit_ready
    );
endinterface

// File: rtl/noc_packetizer.sv
// -----------------------------------------------------------------------------
// noc_packetizer
// Pops 64-bit {addr[63:32], data[31:0]} entries from the AXI4-Lite write FIFO
// and sends each one as a two-flit NoC packet (HEAD then TAIL) to the local
// router over a valid/ready link.
//
// Parameters:
//   SRC_ID : node ID placed in HEAD flit payload bits [27:24]
//   CNT_W  : width of the completed-packet counter
//
// Ports:
//   aclk        : clock, rising edge
//   arestn      : asynchronous active-low reset
//   bus         : noc_packetizer_if.master (FIFO read side + flit link)
//   busy        : high whenever the packetizer is not idle
//   pkt_cnt     : completed packets (TAIL handshakes), wraps
//   flit_parity : even parity over flit_data, only when NOC_PKT_PARITY_EN
//                 is defined
//
// Optional feature macro: NOC_PKT_PARITY_EN (adds flit_parity).
//
// Flit format {type[1:0], payload[31:0]}:
//   HEAD: type 2'b01, payload {addr[31:28], SRC_ID, addr[23:0]}
//   TAIL: type 2'b10, payload data[31:0]
// -----------------------------------------------------------------------------
module noc_packetizer #(
    parameter logic [3:0] SRC_ID = 4'd0,
    parameter int         CNT_W  = 16
) (
    input  logic               aclk,
    input  logic               arestn,
    noc_packetizer_if.master   bus,
    output logic               busy,
    output logic [CNT_W-1:0]   pkt_cnt
`ifdef NOC_PKT_PARITY_EN
    ,
    output logic               flit_parity
`endif
);

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_HEAD  = 3'd3,
        S_TAIL  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               rd_en_q, rd_en_d;
    logic               valid_q, valid_d;
    logic [33:0]        data_q, data_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Only the data half of the entry must be held; the address is consumed
    // into the HEAD flit in the same cycle the entry is captured.
    logic [31:0]        held_q, held_d;
    logic               hs_s;

    // addr[27:24] is replaced by SRC_ID and never used.
    logic               unused_addr_s;
    assign unused_addr_s = ^bus.fifo_rd_data[59:56];

`ifdef NOC_PKT_PARITY_EN
    logic               parity_q, parity_d;

    function automatic logic even_parity34(input logic [33:0] v);
        return ^v;
    endfunction
`endif

    assign hs_s = valid_q & bus.flit_ready;

    // Next-state and next-output logic of the packet FSM.
    always_comb begin
        state_d = state_q;
        rd_en_d = rd_en_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        held_d  = held_q;
        case (state_q)
            S_IDLE: begin
                if (!bus.fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    rd_en_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                // Pop pulse lasts exactly one cycle.
                rd_en_d = 1'b0;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                // FIFO read data is valid now, one cycle after the pop.
                held_d  = bus.fifo_rd_data[31:0];
                valid_d = 1'b1;
                data_d  = {TYPE_HEAD, bus.fifo_rd_data[63:60], SRC_ID,
                           bus.fifo_rd_data[55:32]};
                state_d = S_HEAD;
            end
            S_HEAD: begin
                if (hs_s) begin
                    data_d  = {TYPE_TAIL, held_q};
                    state_d = S_TAIL;
                end else begin
                    state_d = S_HEAD;
                end
            end
            S_TAIL: begin
                if (hs_s) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TAIL;
                end
            end
            default: begin
                rd_en_d = 1'b0;
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

`ifdef NOC_PKT_PARITY_EN
    // Parity follows the flit data it covers, so it stays stable under backpressure.
    always_comb begin
        parity_d = even_parity34(data_d);
    end
`endif

    // State and output registers; reset drops everything to idle at once.
    always_ff @(posedge aclk or negedge arestn) begin
        if (!arestn) begin
            state_q <= S_IDLE;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 34'd0;
            busy_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            held_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
        end
    end

`ifdef NOC_PKT_PARITY_EN
    // Parity register, updated alongside flit_data.
    always_ff @(posedge aclk or negedge arestn) begin
        if (!arestn) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign flit_parity = parity_q;
`endif

    assign bus.fifo_rd_en = rd_en_q;
    assign bus.flit_valid = valid_q;
    assign bus.flit_data  = data_q;
    assign busy           = busy_q;
    assign pkt_cnt        = cnt_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// -----------------------------------------------------------------------------
// tb_noc_packetizer
// Self-checking bench for noc_packetizer (SRC_ID=5, CNT_W=4). A queue-based
// write-FIFO model feeds entries; expected flits are built directly from the
// packet format rules and compared with observed handshakes.
// -----------------------------------------------------------------------------
module tb_noc_packetizer;

    localparam logic [3:0] SRC = 4'd5;

    logic clk = 1'b0;
    logic arestn = 1'b0;
    always #5 clk = ~clk;

    noc_packetizer_if bus();
    logic       busy;
    logic [3:0] pkt_cnt;
`ifdef NOC_PKT_PARITY_EN
    logic       flit_parity;
`endif

    noc_packetizer #(.SRC_ID(SRC), .CNT_W(4)) dut (
        .aclk        (clk),
        .arestn      (arestn),
        .bus         (bus),
        .busy        (busy),
        .pkt_cnt     (pkt_cnt)
`ifdef NOC_PKT_PARITY_EN
        ,
        .flit_parity (flit_parity)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_cnt = 0;
    int rd_pulses = 0;

    logic [63:0] fifo_q[$];
    logic [33:0] exp_q[$];
    logic [33:0] obs_q[$];
    int          obs_cyc[$];
    int          busy_low[$];

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: a pop seen during a cycle presents the entry before the next edge.
    always @(negedge clk) begin
        if (bus.fifo_rd_en) begin
            if (fifo_q.size() > 0) bus.fifo_rd_data = fifo_q.pop_front();
            else                   bus.fifo_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    end

    function automatic logic [33:0] head_of(input logic [63:0] e);
        logic [31:0] addr;
        addr = e[63:32];
        return {2'b01, addr[31:28], SRC, addr[23:0]};
    endfunction

    function automatic logic [33:0] tail_of(input logic [63:0] e);
        return {2'b10, e[31:0]};
    endfunction

    task automatic push_entry(input logic [63:0] e);
        fifo_q.push_back(e);
        exp_q.push_back(head_of(e));
        exp_q.push_back(tail_of(e));
    endtask

    // Move to just after a rising edge so a push is seen by the next falling edge.
    task automatic align();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc.delete();
        busy_low.delete();
        exp_q.delete();
        rd_pulses = 0;
    endtask

    // One cycle: drive ready at the falling edge and record what the link shows.
    task automatic step(input logic rdy);
        @(negedge clk);
        bus.flit_ready = rdy;
        if (bus.flit_valid && bus.flit_ready) begin
            obs_q.push_back(bus.flit_data);
            obs_cyc.push_back(cyc);
        end
        if (bus.fifo_rd_en) rd_pulses++;
        if (!busy) busy_low.push_back(cyc);
    endtask

    task automatic test_reset();
        logic [63:0] e;
        e = {$urandom, $urandom};
        bus.flit_ready = 1'b1;
        arestn = 1'b0;
        fifo_q.push_back(e);
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            checks++;
            if ({bus.fifo_rd_en, bus.flit_valid, busy} !== 3'b000 || bus.flit_data !== 34'd0 || pkt_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_outputs: rd_en=%b valid=%b busy=%b data=%h cnt=%0d, want all 0",
                         bus.fifo_rd_en, bus.flit_valid, busy, bus.flit_data, pkt_cnt);
            end
`ifdef NOC_PKT_PARITY_EN
            checks++;
            if (flit_parity !== 1'b0) begin
                errors++;
                $display("FAIL reset_parity: got %b want 0", flit_parity);
            end
`endif
        end
        checks++;
        if (bus.fifo_empty !== 1'b0 || rd_pulses != 0) begin
            errors++;
            $display("FAIL reset_no_pop: empty=%b pulses=%0d, want empty 0 and 0 pulses", bus.fifo_empty, rd_pulses);
        end
        fifo_q.delete();
        step(1'b0);
        step(1'b0);
        arestn = 1'b1;
        clear_obs();
        for (int i = 0; i < 3; i++) step(1'b0);
        checks++;
        if (rd_pulses != 0) begin
            errors++;
            $display("FAIL idle_after_reset: %0d pops, want 0", rd_pulses);
        end
    endtask

    task automatic test_single();
        clear_obs();
        align();
        push_entry(64'h3A12_3456_DEAD_BEEF);
        step(1'b1);
        step(1'b1);
        checks++;
        if (bus.fifo_rd_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_pop: rd_en=%b busy=%b want 1 1", bus.fifo_rd_en, busy);
        end
        step(1'b1);
        checks++;
        if (bus.fifo_rd_en !== 1'b0 || bus.flit_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: rd_en=%b valid=%b want 0 0", bus.fifo_rd_en, bus.flit_valid);
        end
        step(1'b1);
        checks++;
        if (bus.flit_valid !== 1'b1 || bus.flit_data !== 34'h1_3512_3456) begin
            errors++;
            $display("FAIL single_head: valid=%b data=%h want 1 135123456", bus.flit_valid, bus.flit_data);
        end
        step(1'b1);
        checks++;
        if (bus.flit_valid !== 1'b1 || bus.flit_data !== 34'h2_DEAD_BEEF) begin
            errors++;
            $display("FAIL single_tail: valid=%b data=%h want 1 2deadbeef", bus.flit_valid, bus.flit_data);
        end
        step(1'b1);
        model_cnt++;
        checks++;
        if (bus.flit_valid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 4'(model_cnt % 16) || rd_pulses != 1 || obs_q.size() != 2) begin
            errors++;
            $display("FAIL single_done: valid=%b busy=%b cnt=%0d pulses=%0d flits=%0d want 0 0 %0d 1 2",
                     bus.flit_valid, busy, pkt_cnt, rd_pulses, obs_q.size(), model_cnt % 16);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        int n;
        e = {$urandom, $urandom};
        clear_obs();
        align();
        push_entry(e);
        n = 0;
        step(1'b0);
        while (bus.flit_valid !== 1'b1 && n < 20) begin
            step(1'b0);
            n++;
        end
        checks++;
        if (bus.flit_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout: valid=%b after 20 cycles, want 1", bus.flit_valid);
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            checks++;
            if (bus.flit_valid !== 1'b1 || bus.flit_data !== head_of(e)) begin
                errors++;
                $display("FAIL bp_head_hold: valid=%b data=%h want 1 %h", bus.flit_valid, bus.flit_data, head_of(e));
            end
        end
        step(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            checks++;
            if (bus.flit_valid !== 1'b1 || bus.flit_data !== tail_of(e)) begin
                errors++;
                $display("FAIL bp_tail_hold: valid=%b data=%h want 1 %h", bus.flit_valid, bus.flit_data, tail_of(e));
            end
        end
        step(1'b1);
        step(1'b0);
        model_cnt++;
        checks++;
        if (obs_q.size() != 2 || rd_pulses != 1 || pkt_cnt !== 4'(model_cnt % 16) || bus.flit_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_summary: flits=%0d pulses=%0d cnt=%0d valid=%b want 2 1 %0d 0",
                     obs_q.size(), rd_pulses, pkt_cnt, bus.flit_valid, model_cnt % 16);
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
                errors++;
                $display("FAIL bp_flits: got %h %h want %h %h", obs_q[0], obs_q[1], exp_q[0], exp_q[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_obs();
        align();
        for (int i = 0; i < 4; i++) push_entry({$urandom, $urandom});
        n = 0;
        while (obs_q.size() < 8 && n < 60) begin
            step(1'b1);
`ifdef NOC_PKT_PARITY_EN
            if (bus.flit_valid) begin
                checks++;
                if (flit_parity !== ^bus.flit_data) begin
                    errors++;
                    $display("FAIL b2b_parity: got %b want %b", flit_parity, ^bus.flit_data);
                end
            end
`endif
            n++;
        end
        step(1'b1);
        model_cnt += 4;
        checks++;
        if (obs_q.size() != 8) begin
            errors++;
            $display("FAIL b2b_count: %0d flits want 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (obs_cyc[2*k+1] - obs_cyc[2*k-1] != 5) begin
                    errors++;
                    $display("FAIL b2b_spacing: packet %0d after %0d cycles want 5", k, obs_cyc[2*k+1] - obs_cyc[2*k-1]);
                end
            end
            foreach (busy_low[j]) begin
                for (int k = 0; k < 4; k++) begin
                    if (busy_low[j] >= obs_cyc[2*k] - 2 && busy_low[j] <= obs_cyc[2*k+1]) begin
                        checks++;
                        errors++;
                        $display("FAIL b2b_busy: busy low at cycle %0d inside packet %0d, want 1", busy_low[j], k);
                    end
                end
            end
        end
        checks++;
        if (rd_pulses != 4 || pkt_cnt !== 4'(model_cnt % 16) || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_summary: pulses=%0d cnt=%0d busy=%b want 4 %0d 0", rd_pulses, pkt_cnt, busy, model_cnt % 16);
        end
    endtask

    task automatic test_wrap();
        int n;
        @(negedge clk);
        #2 arestn = 1'b0;
        #1;
        step(1'b0);
        arestn = 1'b1;
        model_cnt = 0;
        clear_obs();
        align();
        for (int i = 0; i < 17; i++) push_entry({$urandom, $urandom});
        n = 0;
        while (obs_q.size() < 34 && n < 1500) begin
            step(1'($urandom_range(0, 9) < 7));
`ifdef NOC_PKT_PARITY_EN
            if (bus.flit_valid) begin
                checks++;
                if (flit_parity !== ^bus.flit_data) begin
                    errors++;
                    $display("FAIL wrap_parity: got %b want %b", flit_parity, ^bus.flit_data);
                end
            end
`endif
            n++;
        end
        step(1'b0);
        model_cnt += 17;
        checks++;
        if (obs_q.size() != 34) begin
            errors++;
            $display("FAIL wrap_timeout: %0d flits want 34", obs_q.size());
        end else begin
            for (int i = 0; i < 34; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL wrap_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (pkt_cnt !== 4'(model_cnt % 16) || rd_pulses != 17) begin
            errors++;
            $display("FAIL wrap_cnt: cnt=%0d pulses=%0d want %0d 17", pkt_cnt, rd_pulses, model_cnt % 16);
        end
    endtask

    task automatic test_reset_mid_tail();
        logic [63:0] e;
        int n;
        e = {$urandom, $urandom};
        clear_obs();
        align();
        push_entry(e);
        n = 0;
        step(1'b0);
        while (bus.flit_valid !== 1'b1 && n < 20) begin
            step(1'b0);
            n++;
        end
        step(1'b1);
        step(1'b0);
        checks++;
        if (bus.flit_valid !== 1'b1 || bus.flit_data !== tail_of(e) || pkt_cnt !== 4'(model_cnt % 16)) begin
            errors++;
            $display("FAIL mid_tail_setup: valid=%b data=%h cnt=%0d want 1 %h %0d",
                     bus.flit_valid, bus.flit_data, pkt_cnt, tail_of(e), model_cnt % 16);
        end
        #2 arestn = 1'b0;
        #1;
        model_cnt = 0;
        checks++;
        if (bus.flit_valid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 4'd0 || bus.flit_data !== 34'd0) begin
            errors++;
            $display("FAIL mid_tail_reset: valid=%b busy=%b cnt=%0d data=%h want 0 0 0 0",
                     bus.flit_valid, busy, pkt_cnt, bus.flit_data);
        end
        step(1'b1);
        arestn = 1'b1;
        clear_obs();
        for (int i = 0; i < 6; i++) step(1'b1);
        checks++;
        if (rd_pulses != 0 || obs_q.size() != 0 || bus.flit_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_tail_replay: pulses=%0d flits=%0d valid=%b want 0 0 0",
                     rd_pulses, obs_q.size(), bus.flit_valid);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flit_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_reset_mid_tail();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
